wb_crossbar_arbiter: RTL and testbench

//  Decode + arbitration stage for the Wishbone crossbar. Maps each master address to a slave via ADDR/MASK/WHITE_LIST.

---
 rtl/wb_crossbar_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_wb_crossbar_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wb_crossbar_arbiter.sv
// Wishbone crossbar decode and per-slave round-robin arbitration with decode-error responses.
// Optional per-slave watchdog is enabled by defining WB_XBAR_TIMEOUT_EN.
module wb_crossbar_arbiter #(
    parameter int unsigned              NM         = 2,
    parameter int unsigned              NS         = 2,
    parameter int unsigned              AW         = 32,
    parameter logic [NS-1:0][AW-1:0]    ADDR_MAP   = '0,
    parameter logic [NS-1:0][AW-1:0]    MASK_MAP   = '0,
    parameter logic [NM-1:0][NS-1:0]    WHITE_LIST = '0,
    parameter int unsigned              TO_CYCLES  = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NM-1:0]       i_cyc,
    input  logic [NM-1:0]       i_stb,
    input  logic [NM*AW-1:0]    i_addr,
    input  logic [NS-1:0]       i_ack,
    input  logic [NS-1:0]       i_err,
    output logic [NM*NS-1:0]    o_grant,
    output logic [NS-1:0]       o_busy,
    output logic [NM-1:0]       o_derr,
    output logic [NM-1:0]       o_terr
);

    localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned CW = $clog2(TO_CYCLES + 1);

    typedef enum logic {S_IDLE, S_OWNED} slv_state_e;
    typedef enum logic [1:0] {D_IDLE, D_ERR, D_HOLD} derr_state_e;

    // Overlaps only matter between slaves that one master is allowed to reach.
    function automatic logic map_overlap();
        for (int i = 0; i < int'(NS); i++) begin
            for (int j = i + 1; j < int'(NS); j++) begin
                for (int m = 0; m < int'(NM); m++) begin
                    if (WHITE_LIST[m][i] && WHITE_LIST[m][j] &&
                        (((ADDR_MAP[i] ^ ADDR_MAP[j]) & MASK_MAP[i] & MASK_MAP[j]) == '0))
                        return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    if (NM < 1 || NS < 1) begin : g_bad_size
        $error("wb_crossbar_arbiter: NM and NS must be >= 1");
    end
    if (map_overlap()) begin : g_bad_map
        $error("wb_crossbar_arbiter: overlapping slave address ranges");
    end

    slv_state_e             st_q   [NS];
    slv_state_e             st_d   [NS];
    derr_state_e            ds_q   [NM];
    derr_state_e            ds_d   [NM];
    logic [NS-1:0][MW-1:0]  own_q, own_d, ptr_q, ptr_d;
    logic [NM*NS-1:0]       grant_q, grant_d;
    logic [NS-1:0]          busy_q, busy_d;
    logic [NM-1:0]          derr_q, derr_d, terr_q, terr_d, blk_q, blk_d;
    logic [NM-1:0][NS-1:0]  hit, req;
    logic [NM-1:0]          owns;
    logic [NS-1:0]          to_fire;

    // Address decode; masters that own a slave or sit out a watchdog kill do not request.
    always_comb begin
        hit  = '0;
        req  = '0;
        owns = '0;
        for (int m = 0; m < int'(NM); m++) begin
            owns[m] = |grant_q[m*NS +: NS];
            for (int s = 0; s < int'(NS); s++) begin
                hit[m][s] = ((i_addr[m*AW +: AW] & MASK_MAP[s]) == ADDR_MAP[s]);
                req[m][s] = i_cyc[m] & i_stb[m] & hit[m][s] & WHITE_LIST[m][s]
                          & ~owns[m] & ~blk_q[m];
            end
        end
    end

    // Per-slave ownership FSM with round-robin pick after the last winner.
    always_comb begin
        int   o;
        int   idx;
        int   pick;
        logic found;
        logic rel;
        logic arb;
        st_d    = st_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = '0;
        terr_d  = '0;
        blk_d   = '0;
        o       = 0;
        idx     = 0;
        pick    = 0;
        found   = 1'b0;
        rel     = 1'b0;
        arb     = 1'b0;
        for (int s = 0; s < int'(NS); s++) begin
            o   = int'(own_q[s]);
            rel = 1'b0;
            arb = 1'b0;
            case (st_q[s])
                S_IDLE: arb = 1'b1;
                S_OWNED: begin
                    if (!i_cyc[o]) begin
                        rel = 1'b1;
                        arb = 1'b1;
                    end else if (to_fire[s]) begin
                        rel       = 1'b1;
                        terr_d[o] = 1'b1;
                    end
                end
                default: arb = 1'b1;
            endcase
            if (rel) begin
                grant_d[o*NS + s] = 1'b0;
                st_d[s]           = S_IDLE;
            end
            if (arb) begin
                found = 1'b0;
                pick  = 0;
                for (int i = 1; i <= int'(NM); i++) begin
                    idx = (int'(ptr_q[s]) + i) % int'(NM);
                    if (!found && req[idx][s]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    st_d[s]              = S_OWNED;
                    own_d[s]             = MW'(pick);
                    ptr_d[s]             = MW'(pick);
                    grant_d[pick*NS + s] = 1'b1;
                end
            end
            busy_d[s] = (st_d[s] == S_OWNED);
        end
        for (int m = 0; m < int'(NM); m++) begin
            blk_d[m] = terr_d[m] | (blk_q[m] & i_cyc[m]);
        end
    end

    // Decode-error responder: one pulse, then at least one quiet cycle.
    always_comb begin
        ds_d   = ds_q;
        derr_d = '0;
        for (int m = 0; m < int'(NM); m++) begin
            case (ds_q[m])
                D_IDLE: begin
                    if (i_cyc[m] && i_stb[m] && !owns[m] && ((hit[m] & WHITE_LIST[m]) == '0)) begin
                        ds_d[m]   = D_ERR;
                        derr_d[m] = 1'b1;
                    end
                end
                D_ERR:   ds_d[m] = D_HOLD;
                D_HOLD:  ds_d[m] = D_IDLE;
                default: ds_d[m] = D_IDLE;
            endcase
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    logic [NS-1:0][CW-1:0] cnt_q, cnt_d;

    // Watchdog counts stalled owned cycles; ack, err or release clears it.
    always_comb begin
        int o;
        o       = 0;
        cnt_d   = '0;
        to_fire = '0;
        for (int s = 0; s < int'(NS); s++) begin
            o = int'(own_q[s]);
            if (st_q[s] == S_OWNED && i_cyc[o] && i_stb[o] && !i_ack[s] && !i_err[s]) begin
                if (cnt_q[s] == CW'(TO_CYCLES - 1)) to_fire[s] = 1'b1;
                else cnt_d[s] = cnt_q[s] + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_sink;
    assign unused_sink = ^{i_ack, i_err, CW'(TO_CYCLES)};
    assign to_fire     = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < int'(NS); s++) begin
                st_q[s]  <= S_IDLE;
                ptr_q[s] <= MW'(NM - 1);
            end
            for (int m = 0; m < int'(NM); m++) ds_q[m] <= D_IDLE;
            own_q   <= '0;
            grant_q <= '0;
            busy_q  <= '0;
            derr_q  <= '0;
            terr_q  <= '0;
            blk_q   <= '0;
        end else begin
            st_q    <= st_d;
            ds_q    <= ds_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            derr_q  <= derr_d;
            terr_q  <= terr_d;
            blk_q   <= blk_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = busy_q;
    assign o_derr  = derr_q;
    assign o_terr  = terr_q;

endmodule

// File: tb/tb_wb_crossbar_arbiter.sv
// Directed bench for wb_crossbar_arbiter: scoreboard queue of expected outputs, checked after each edge.
module tb_wb_crossbar_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cyc, stb, ack, err;
    logic [63:0] addr;
    logic [3:0]  grant, grant2;
    logic [1:0]  busy, busy2, derr, derr2, terr, terr2;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [1:0] busy;
        logic [1:0] derr;
        logic [1:0] terr;
        logic       chk2;
        logic [1:0] derr2;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_crossbar_arbiter #(
        .NM(2), .NS(2), .AW(32),
        .ADDR_MAP({32'h1000_0000, 32'h0000_0000}),
        .MASK_MAP({32'hF000_0000, 32'hF000_0000}),
        .WHITE_LIST(4'b1111),
        .TO_CYCLES(4)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc), .i_stb(stb), .i_addr(addr),
        .i_ack(ack), .i_err(err), .o_grant(grant), .o_busy(busy), .o_derr(derr), .o_terr(terr)
    );

    // Same map, but master 1 may not reach slave 1.
    wb_crossbar_arbiter #(
        .NM(2), .NS(2), .AW(32),
        .ADDR_MAP({32'h1000_0000, 32'h0000_0000}),
        .MASK_MAP({32'hF000_0000, 32'hF000_0000}),
        .WHITE_LIST(4'b0111),
        .TO_CYCLES(4)
    ) u_dut_wl (
        .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc), .i_stb(stb), .i_addr(addr),
        .i_ack(ack), .i_err(err), .o_grant(grant2), .o_busy(busy2), .o_derr(derr2), .o_terr(terr2)
    );

    task automatic step(input string tag, input logic [3:0] g, input logic [1:0] b,
                        input logic [1:0] d, input logic [1:0] t,
                        input logic c2 = 1'b0, input logic [1:0] d2 = 2'b00);
        exp_t e;
        e.tag = tag; e.grant = g; e.busy = b; e.derr = d; e.terr = t; e.chk2 = c2; e.derr2 = d2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        assert ({grant, busy, derr, terr} === {e.grant, e.busy, e.derr, e.terr}) else begin
            miscompares++;
            $error("FAIL %s: observed grant=%b busy=%b derr=%b terr=%b expected grant=%b busy=%b derr=%b terr=%b",
                   e.tag, grant, busy, derr, terr, e.grant, e.busy, e.derr, e.terr);
        end
        if (e.chk2) begin
            vectors++;
            assert (derr2 === e.derr2) else begin
                miscompares++;
                $error("FAIL %s_wl: observed derr=%b expected derr=%b", e.tag, derr2, e.derr2);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = '0; stb = '0; addr = '0;
        step("reset", 4'b0000, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = '0; stb = '0; ack = '0; err = '0; addr = '0;

        // Reset held while master 0 strobes slave 0
        cyc = 2'b01; stb = 2'b01; addr[31:0] = 32'h0000_0040;
        step("rst_hold0", 4'b0000, 2'b00, 2'b00, 2'b00);
        step("rst_hold1", 4'b0000, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        step("rst_rel", 4'b0001, 2'b01, 2'b00, 2'b00);
        cyc = 2'b00; stb = 2'b00;
        step("rst_drop", 4'b0000, 2'b00, 2'b00, 2'b00);

        // Contention and bubble-free handover
        do_reset();
        cyc = 2'b11; stb = 2'b11; addr = {32'h0000_0100, 32'h0000_0100};
        step("cont_m0", 4'b0001, 2'b01, 2'b00, 2'b00);
        cyc = 2'b10; stb = 2'b10;
        step("cont_hand", 4'b0100, 2'b01, 2'b00, 2'b00);
        cyc = 2'b00; stb = 2'b00;
        step("cont_end", 4'b0000, 2'b00, 2'b00, 2'b00);

        // Fairness: alternating winners under constant contention
        do_reset();
        addr = '0;
        for (int r = 0; r < 4; r++) begin
            cyc = 2'b11; stb = 2'b11;
            step($sformatf("fair_g%0d", r), (r % 2 == 1) ? 4'b0100 : 4'b0001, 2'b01, 2'b00, 2'b00);
            cyc = 2'b00; stb = 2'b00;
            step($sformatf("fair_i%0d", r), 4'b0000, 2'b00, 2'b00, 2'b00);
        end

        // Parallel grants to distinct slaves
        cyc = 2'b11; stb = 2'b11; addr = {32'h1000_0000, 32'h0000_0000};
        step("par", 4'b1001, 2'b11, 2'b00, 2'b00);
        cyc = 2'b00; stb = 2'b00;
        step("par_end", 4'b0000, 2'b00, 2'b00, 2'b00);

        // Decode error on an unmapped address
        cyc = 2'b10; stb = 2'b10; addr = {32'h2000_0000, 32'h0000_0000};
        step("derr1", 4'b0000, 2'b00, 2'b10, 2'b00);
        step("derr2", 4'b0000, 2'b00, 2'b00, 2'b00);
        step("derr3", 4'b0000, 2'b00, 2'b00, 2'b00);
        step("derr4", 4'b0000, 2'b00, 2'b10, 2'b00);
        cyc = 2'b00; stb = 2'b00;
        step("derr_hold", 4'b0000, 2'b00, 2'b00, 2'b00);
        step("derr_idle", 4'b0000, 2'b00, 2'b00, 2'b00);

        // Decode error on a mapped but non-whitelisted slave
        cyc = 2'b10; stb = 2'b10; addr = {32'h1000_0000, 32'h0000_0000};
        step("wl1", 4'b1000, 2'b10, 2'b00, 2'b00, 1'b1, 2'b10);
        step("wl2", 4'b1000, 2'b10, 2'b00, 2'b00, 1'b1, 2'b00);
        step("wl3", 4'b1000, 2'b10, 2'b00, 2'b00, 1'b1, 2'b00);
        step("wl4", 4'b1000, 2'b10, 2'b00, 2'b00, 1'b1, 2'b10);
        cyc = 2'b00; stb = 2'b00;
        step("wl_hold", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        step("wl_idle", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00);

        // Master 0 owns slave 1 and is never acknowledged
        cyc = 2'b01; stb = 2'b01; addr = {32'h0000_0000, 32'h1000_0000};
        step("to_own1", 4'b0010, 2'b10, 2'b00, 2'b00);
`ifdef WB_XBAR_TIMEOUT_EN
        step("to_own2", 4'b0010, 2'b10, 2'b00, 2'b00);
        step("to_own3", 4'b0010, 2'b10, 2'b00, 2'b00);
        step("to_own4", 4'b0010, 2'b10, 2'b00, 2'b00);
        step("to_fire", 4'b0000, 2'b00, 2'b00, 2'b01);
        step("to_block", 4'b0000, 2'b00, 2'b00, 2'b00);
        cyc = 2'b00; stb = 2'b00;
        step("to_drop", 4'b0000, 2'b00, 2'b00, 2'b00);
        cyc = 2'b01; stb = 2'b01;
        step("to_regrant", 4'b0010, 2'b10, 2'b00, 2'b00);
`else
        for (int k = 2; k <= 7; k++) begin
            step($sformatf("to_hold%0d", k), 4'b0010, 2'b10, 2'b00, 2'b00);
        end
`endif
        cyc = 2'b00; stb = 2'b00;
        step("to_end", 4'b0000, 2'b00, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
